// File: rtl/regfile_writeback_queue.sv
// Register-file writeback queue: arbitrates ALU/load writebacks into an in-order FIFO,
// drains one entry per cycle to the write port, and forwards the youngest queued value to decode.
module regfile_writeback_queue #(
    parameter int dataW = 32,
    parameter int addrW = 5,
    parameter int depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             AluValid,
    output logic             AluReady,
    input  logic [addrW-1:0] AluAddr,
    input  logic [dataW-1:0] AluData,
    input  logic             MemValid,
    output logic             MemReady,
    input  logic [addrW-1:0] MemAddr,
    input  logic [dataW-1:0] MemData,
    input  logic             WbStall,
    output logic             RegWriteControl,
    output logic [addrW-1:0] RegWriteAddr,
    output logic [dataW-1:0] RegDataIn,
    input  logic [addrW-1:0] RegRead1,
    input  logic [addrW-1:0] RegRead2,
    output logic             Pending1,
    output logic             Pending2,
    output logic [dataW-1:0] FwdData1,
    output logic [dataW-1:0] FwdData2
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    logic [addrW-1:0] addr_q [depth];
    logic [dataW-1:0] data_q [depth];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             full, nonempty;
    logic             mem_fire, alu_fire, push, pop;
    logic [addrW-1:0] push_addr;
    logic [dataW-1:0] push_data;

    always_comb begin
        full     = (count_q == CW'(depth));
        MemReady = !reset && !full;
        AluReady = !reset && !full && !MemValid;
        mem_fire = MemValid && MemReady;
        alu_fire = AluValid && AluReady;

        push_addr = mem_fire ? MemAddr : AluAddr;
        push_data = mem_fire ? MemData : AluData;
        // x0 writes complete the handshake but are dropped here
        push      = (mem_fire || alu_fire) && (push_addr != '0);

        nonempty        = !reset && (count_q != '0);
        RegWriteControl = nonempty && !WbStall;
        RegWriteAddr    = nonempty ? addr_q[rd_ptr_q] : '0;
        RegDataIn       = nonempty ? data_q[rd_ptr_q] : '0;
        pop             = RegWriteControl;

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= push_addr;
                data_q[wr_ptr_q] <= push_data;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Oldest-to-youngest scan so the last match wins (youngest value forwarded)
    logic [PW-1:0] idx;
    always_comb begin
        Pending1 = 1'b0;
        Pending2 = 1'b0;
        FwdData1 = '0;
        FwdData2 = '0;
        idx      = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (!reset && (CW'(i) < count_q)) begin
                if (RegRead1 != '0 && addr_q[idx] == RegRead1) begin
                    Pending1 = 1'b1;
                    FwdData1 = data_q[idx];
                end
                if (RegRead2 != '0 && addr_q[idx] == RegRead2) begin
                    Pending2 = 1'b1;
                    FwdData2 = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: hand-derived vector table plus a queue-based reference model
// that predicts readiness, write-port traffic and forwarding every cycle.
module tb_regfile_writeback_queue;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          AluValid, MemValid, WbStall;
    logic          AluReady, MemReady;
    logic [AW-1:0] AluAddr, MemAddr, RegRead1, RegRead2, RegWriteAddr;
    logic [DW-1:0] AluData, MemData, RegDataIn, FwdData1, FwdData2;
    logic          RegWriteControl, Pending1, Pending2;

    always #5 clock = ~clock;

    regfile_writeback_queue #(.dataW(DW), .addrW(AW), .depth(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .AluValid(AluValid), .AluReady(AluReady), .AluAddr(AluAddr), .AluData(AluData),
        .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemData(MemData),
        .WbStall(WbStall),
        .RegWriteControl(RegWriteControl), .RegWriteAddr(RegWriteAddr), .RegDataIn(RegDataIn),
        .RegRead1(RegRead1), .RegRead2(RegRead2),
        .Pending1(Pending1), .Pending2(Pending2), .FwdData1(FwdData1), .FwdData2(FwdData2)
    );

    typedef struct {
        logic          rst, mv;
        logic [AW-1:0] ma;
        logic [DW-1:0] md;
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          stall;
        logic [AW-1:0] r1, r2;
        logic          wc;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          mr, ar, p1;
        logic [DW-1:0] f1;
        logic          p2;
        logic [DW-1:0] f2;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check table expectations (optional) and model, advance model.
    task automatic cycle(input vec_t v, input bit use_exp);
        logic          e_mr, e_ar, e_wc, e_p1, e_p2;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd, e_f1, e_f2;
        @(negedge clock);
        reset = v.rst; MemValid = v.mv; MemAddr = v.ma; MemData = v.md;
        AluValid = v.av; AluAddr = v.aa; AluData = v.ad; WbStall = v.stall;
        RegRead1 = v.r1; RegRead2 = v.r2;
        #1;
        if (use_exp) begin
            chk("tbl_wc", RegWriteControl, v.wc);
            chk("tbl_waddr", RegWriteAddr, v.wa);
            chk("tbl_wdata", RegDataIn, v.wd);
            chk("tbl_memready", MemReady, v.mr);
            chk("tbl_aluready", AluReady, v.ar);
            chk("tbl_pend1", Pending1, v.p1);
            chk("tbl_fwd1", FwdData1, v.f1);
            chk("tbl_pend2", Pending2, v.p2);
            chk("tbl_fwd2", FwdData2, v.f2);
        end
        e_mr = !v.rst && (sb.size() < DEPTH);
        e_ar = e_mr && !v.mv;
        e_wc = !v.rst && (sb.size() != 0) && !v.stall;
        e_wa = '0; e_wd = '0;
        if (!v.rst && sb.size() != 0) begin
            e_wa = sb[0].addr; e_wd = sb[0].data;
        end
        e_p1 = 1'b0; e_f1 = '0; e_p2 = 1'b0; e_f2 = '0;
        if (!v.rst) begin
            foreach (sb[k]) begin
                if (v.r1 != '0 && sb[k].addr == v.r1) begin e_p1 = 1'b1; e_f1 = sb[k].data; end
                if (v.r2 != '0 && sb[k].addr == v.r2) begin e_p2 = 1'b1; e_f2 = sb[k].data; end
            end
        end
        chk("sb_memready", MemReady, e_mr);
        chk("sb_aluready", AluReady, e_ar);
        chk("sb_wc", RegWriteControl, e_wc);
        chk("sb_waddr", RegWriteAddr, e_wa);
        chk("sb_wdata", RegDataIn, e_wd);
        chk("sb_pend1", Pending1, e_p1);
        chk("sb_fwd1", FwdData1, e_f1);
        chk("sb_pend2", Pending2, e_p2);
        chk("sb_fwd2", FwdData2, e_f2);
        @(posedge clock);
        if (v.rst) begin
            sb.delete();
        end else begin
            if (e_wc) void'(sb.pop_front());
            if (v.mv && e_mr) begin
                if (v.ma != '0) sb.push_back('{v.ma, v.md});
            end else if (v.av && e_ar) begin
                if (v.aa != '0) sb.push_back('{v.aa, v.ad});
            end
        end
    endtask

    function automatic vec_t idle(input logic stall, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        vec_t v;
        v = '{default: '0};
        v.stall = stall; v.r1 = r1; v.r2 = r2;
        return v;
    endfunction

    function automatic vec_t alu(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic stall);
        vec_t v;
        v = idle(stall, '0, '0);
        v.av = 1'b1; v.aa = a; v.ad = d;
        return v;
    endfunction

    vec_t vecs[10];
    vec_t v;

    initial begin
        reset = 1'b1; AluValid = 0; MemValid = 0; WbStall = 0;
        AluAddr = '0; AluData = '0; MemAddr = '0; MemData = '0; RegRead1 = '0; RegRead2 = '0;

        //         rst mv ma md  av aa ad  st r1 r2 | wc wa wd  mr ar p1 f1  p2 f2
        vecs[0] = '{1, 0, 0, 0,   0, 0, 0,   0, 0, 0,  0, 0, 0,   0, 0, 0, 0,   0, 0};
        vecs[1] = '{0, 0, 0, 0,   1, 1, 897, 0, 1, 0,  0, 0, 0,   1, 1, 0, 0,   0, 0};
        vecs[2] = '{0, 0, 0, 0,   0, 0, 0,   0, 1, 0,  1, 1, 897, 1, 1, 1, 897, 0, 0};
        vecs[3] = '{0, 0, 0, 0,   0, 0, 0,   0, 1, 0,  0, 0, 0,   1, 1, 0, 0,   0, 0};
        vecs[4] = '{0, 1, 2, 666, 1, 3, 65,  0, 0, 0,  0, 0, 0,   1, 0, 0, 0,   0, 0};
        vecs[5] = '{0, 0, 0, 0,   1, 3, 65,  0, 2, 3,  1, 2, 666, 1, 1, 1, 666, 0, 0};
        vecs[6] = '{0, 0, 0, 0,   0, 0, 0,   0, 0, 3,  1, 3, 65,  1, 1, 0, 0,   1, 65};
        vecs[7] = '{0, 0, 0, 0,   0, 0, 0,   0, 0, 3,  0, 0, 0,   1, 1, 0, 0,   0, 0};
        vecs[8] = '{0, 0, 0, 0,   1, 0, 99,  0, 0, 0,  0, 0, 0,   1, 1, 0, 0,   0, 0};
        vecs[9] = '{0, 0, 0, 0,   0, 0, 0,   0, 0, 0,  0, 0, 0,   1, 1, 0, 0,   0, 0};

        for (int i = 0; i < 10; i++) cycle(vecs[i], 1'b1);

        // Fill under stall, then hold a request against the full queue before draining
        for (int i = 0; i < DEPTH; i++) cycle(alu(AW'(10 + i), DW'(100 + i), 1'b1), 1'b0);
        v = alu(5'd20, 32'd555, 1'b1);
        cycle(v, 1'b0);
        chk("full_aluready", AluReady, 1'b0);
        chk("full_memready", MemReady, 1'b0);
        chk("full_stalled_wc", RegWriteControl, 1'b0);
        v.stall = 1'b0;
        cycle(v, 1'b0);
        chk("full_pop_noready", AluReady, 1'b0);
        for (int i = 0; i < 6; i++) cycle(idle(1'b0, '0, '0), 1'b0);
        chk("drained_aluready", AluReady, 1'b1);

        // Two queued writes to the same register: youngest one forwards
        cycle(alu(5'd4, 32'd10, 1'b1), 1'b0);
        cycle(alu(5'd4, 32'd20, 1'b1), 1'b0);
        cycle(idle(1'b1, 5'd4, 5'd5), 1'b0);
        chk("fwd_pend1", Pending1, 1'b1);
        chk("fwd_data1", FwdData1, 32'd20);
        chk("fwd_pend2", Pending2, 1'b0);
        chk("fwd_data2", FwdData2, 32'd0);
        for (int i = 0; i < 3; i++) cycle(idle(1'b0, 5'd4, '0), 1'b0);

        // Reset with stale entries queued under stall; they must never be written
        for (int i = 0; i < 3; i++) cycle(alu(AW'(7 + i), DW'(70 + i), 1'b1), 1'b0);
        v = idle(1'b1, 5'd7, '0);
        v.rst = 1'b1;
        cycle(v, 1'b0);
        chk("rst_memready", MemReady, 1'b0);
        chk("rst_aluready", AluReady, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(idle(1'b0, 5'd7, 5'd8), 1'b0);
            chk("post_rst_wc", RegWriteControl, 1'b0);
            chk("post_rst_pend1", Pending1, 1'b0);
            chk("post_rst_ready", MemReady, 1'b1);
        end

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            v = idle(($urandom_range(0, 9) < 3), AW'($urandom_range(0, 6)), AW'($urandom_range(0, 6)));
            v.mv = ($urandom_range(0, 3) == 0);
            v.ma = AW'($urandom_range(0, 6));
            v.md = $urandom;
            v.av = ($urandom_range(0, 1) == 0);
            v.aa = AW'($urandom_range(0, 6));
            v.ad = $urandom;
            cycle(v, 1'b0);
        end
        for (int i = 0; i < 8; i++) cycle(idle(1'b0, '0, '0), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
